// File: rtl/s1_unidade_controle.sv
// S1 game control unit: Moore FSM sequencing rounds, notes, plays and scoring.
// Owns every datapath strobe; latches difficulty and song at game start.

package s1_pkg;
  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARA       = 4'h1,
    INICIO_RODADA = 4'h2,
    MOSTRA_NOTA   = 4'h3,
    PROX_MOSTRA   = 4'h4,
    FIM_MOSTRA    = 4'h5,
    ESPERA_JOGADA = 4'h6,
    REGISTRA      = 4'h7,
    COMPARA       = 4'h8,
    ERRO          = 4'h9,
    PROX_JOGADA   = 4'hA,
    FIM_RODADA    = 4'hB,
    PROX_RODADA   = 4'hC,
    FIM_JOGO      = 4'hD
  } estado_t;
endpackage

module s1_unidade_controle
  import s1_pkg::*;
#(
  parameter bit TIMEOUT_ENCERRA = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       nivel_in,
  input  logic       musica_in,
  input  logic       fimL,
  input  logic       enderecoIgualLimite,
  input  logic       botoesIgualMemoria,
  input  logic       jogadafeita,
  input  logic       timeout,
  input  logic       muda_nota,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraR,
  output logic       registraR,
  output logic       zeraT,
  output logic       contaT,
  output logic       zeraT2,
  output logic       contaT2,
  output logic       zeraErro,
  output logic       contaErro,
  output logic       zeraPontos,
  output logic       regPontos,
  output logic       mostraJ,
  output logic       mostraB,
  output logic       sel_memoria_arduino,
  output logic       activateArduino,
  output logic       nivel,
  output logic       memoria,
  output logic       fim_jogo,
  output logic       perdeu_timeout,
  output logic [3:0] db_estado
);

  estado_t estado;
  estado_t estado_prox;
  logic    fim_por_timeout;

  // state register, async return to INICIAL
  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= INICIAL;
    else       estado <= estado_prox;
  end

  // next-state logic; a play beats a same-cycle timeout
  always_comb begin
    estado_prox = estado;
    unique case (estado)
      INICIAL:
        if (iniciar) estado_prox = PREPARA;
      PREPARA:
        estado_prox = INICIO_RODADA;
      INICIO_RODADA:
        estado_prox = MOSTRA_NOTA;
      MOSTRA_NOTA:
        if (muda_nota)
          estado_prox = enderecoIgualLimite ? FIM_MOSTRA
                                            : PROX_MOSTRA;
      PROX_MOSTRA:
        estado_prox = MOSTRA_NOTA;
      FIM_MOSTRA:
        estado_prox = ESPERA_JOGADA;
      ESPERA_JOGADA:
        if (jogadafeita)
          estado_prox = REGISTRA;
        else if (timeout)
          estado_prox = TIMEOUT_ENCERRA ? FIM_JOGO : ERRO;
      REGISTRA:
        estado_prox = COMPARA;
      COMPARA:
        if (!botoesIgualMemoria)
          estado_prox = ERRO;
        else if (enderecoIgualLimite)
          estado_prox = FIM_RODADA;
        else
          estado_prox = PROX_JOGADA;
      ERRO:
        estado_prox = enderecoIgualLimite ? FIM_RODADA
                                          : PROX_JOGADA;
      PROX_JOGADA:
        estado_prox = ESPERA_JOGADA;
      FIM_RODADA:
        estado_prox = fimL ? FIM_JOGO : PROX_RODADA;
      PROX_RODADA:
        estado_prox = INICIO_RODADA;
      FIM_JOGO:
        if (iniciar) estado_prox = PREPARA;
      default:
        estado_prox = INICIAL;
    endcase
  end

  // Moore strobe decode, purely from the current state
  always_comb begin
    zeraL               = 1'b0;
    contaL              = 1'b0;
    zeraE               = 1'b0;
    contaE              = 1'b0;
    zeraR               = 1'b0;
    registraR           = 1'b0;
    zeraT               = 1'b0;
    contaT              = 1'b0;
    zeraT2              = 1'b0;
    contaT2             = 1'b0;
    zeraErro            = 1'b0;
    contaErro           = 1'b0;
    zeraPontos          = 1'b0;
    regPontos           = 1'b0;
    mostraJ             = 1'b0;
    mostraB             = 1'b0;
    sel_memoria_arduino = 1'b0;
    activateArduino     = 1'b0;
    fim_jogo            = 1'b0;
    unique case (estado)
      PREPARA: begin
        zeraL      = 1'b1;
        zeraE      = 1'b1;
        zeraR      = 1'b1;
        zeraT      = 1'b1;
        zeraT2     = 1'b1;
        zeraErro   = 1'b1;
        zeraPontos = 1'b1;
      end
      INICIO_RODADA: begin
        zeraE    = 1'b1;
        zeraT2   = 1'b1;
        zeraErro = 1'b1;
      end
      MOSTRA_NOTA: begin
        mostraJ             = 1'b1;
        contaT2             = 1'b1;
        sel_memoria_arduino = 1'b1;
        activateArduino     = 1'b1;
      end
      PROX_MOSTRA: begin
        contaE = 1'b1;
        zeraT2 = 1'b1;
      end
      FIM_MOSTRA: begin
        zeraE = 1'b1;
        zeraR = 1'b1;
        zeraT = 1'b1;
      end
      ESPERA_JOGADA: begin
        contaT          = 1'b1;
        mostraB         = 1'b1;
        activateArduino = 1'b1;
      end
      REGISTRA: begin
        registraR = 1'b1;
        mostraB   = 1'b1;
      end
      ERRO:
        contaErro = 1'b1;
      PROX_JOGADA: begin
        contaE = 1'b1;
        zeraT  = 1'b1;
      end
      FIM_RODADA:
        regPontos = 1'b1;
      PROX_RODADA:
        contaL = 1'b1;
      FIM_JOGO:
        fim_jogo = 1'b1;
      default: ;
    endcase
  end

  assign db_estado = estado;

  assign fim_por_timeout = TIMEOUT_ENCERRA
                        && (estado == ESPERA_JOGADA)
                        && timeout
                        && !jogadafeita;

  // game configuration and timeout flag, refreshed at each PREPARA
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      nivel          <= 1'b0;
      memoria        <= 1'b0;
      perdeu_timeout <= 1'b0;
    end else if (estado == PREPARA) begin
      nivel          <= nivel_in;
      memoria        <= musica_in;
      perdeu_timeout <= 1'b0;
    end else if (fim_por_timeout) begin
      perdeu_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_s1_unidade_controle.sv
// Directed bench for s1_unidade_controle with a small datapath model.
// Two instances cover both timeout policies.

module tb_s1_unidade_controle;

  logic clock = 1'b0;
  logic reset, iniciar, nivel_in, musica_in;
  logic botoesIgualMemoria, jogadafeita, timeout, muda_nota;
  logic fimL, enderecoIgualLimite;

  logic zeraL, contaL, zeraE, contaE, zeraR, registraR;
  logic zeraT, contaT, zeraT2, contaT2, zeraErro, contaErro;
  logic zeraPontos, regPontos, mostraJ, mostraB;
  logic sel_memoria_arduino, activateArduino;
  logic nivel, memoria, fim_jogo, perdeu_timeout;
  logic [3:0] db_estado;

  logic zeraL_0, contaL_0, zeraE_0, contaE_0, zeraR_0, registraR_0;
  logic zeraT_0, contaT_0, zeraT2_0, contaT2_0, zeraErro_0, contaErro_0;
  logic zeraPontos_0, regPontos_0, mostraJ_0, mostraB_0;
  logic sel_memoria_arduino_0, activateArduino_0;
  logic nivel_0, memoria_0, fim_jogo_0, perdeu_timeout_0;
  logic [3:0] db_estado_0;

  int checks = 0;
  int errors = 0;

  localparam logic [17:0] ST_PREPARA  = 18'b1010101010_1010_00_00;
  localparam logic [17:0] ST_MOSTRA   = 18'b0000000001_0000_10_11;
  localparam logic [17:0] ST_ESPERA   = 18'b0000000100_0000_01_01;
  localparam logic [17:0] ST_REGISTRA = 18'b0000010000_0000_01_00;
  localparam logic [17:0] ST_ERRO     = 18'b0000000000_0100_00_00;
  localparam logic [17:0] ST_FIM_ROD  = 18'b0000000000_0001_00_00;

  logic [17:0] st;
  assign st = {zeraL, contaL, zeraE, contaE, zeraR, registraR,
               zeraT, contaT, zeraT2, contaT2,
               zeraErro, contaErro, zeraPontos, regPontos,
               mostraJ, mostraB, sel_memoria_arduino, activateArduino};

  s1_unidade_controle #(.TIMEOUT_ENCERRA(1'b1)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .nivel_in(nivel_in), .musica_in(musica_in), .fimL(fimL),
    .enderecoIgualLimite(enderecoIgualLimite),
    .botoesIgualMemoria(botoesIgualMemoria),
    .jogadafeita(jogadafeita), .timeout(timeout), .muda_nota(muda_nota),
    .zeraL(zeraL), .contaL(contaL), .zeraE(zeraE), .contaE(contaE),
    .zeraR(zeraR), .registraR(registraR), .zeraT(zeraT), .contaT(contaT),
    .zeraT2(zeraT2), .contaT2(contaT2), .zeraErro(zeraErro),
    .contaErro(contaErro), .zeraPontos(zeraPontos), .regPontos(regPontos),
    .mostraJ(mostraJ), .mostraB(mostraB),
    .sel_memoria_arduino(sel_memoria_arduino),
    .activateArduino(activateArduino), .nivel(nivel), .memoria(memoria),
    .fim_jogo(fim_jogo), .perdeu_timeout(perdeu_timeout),
    .db_estado(db_estado)
  );

  s1_unidade_controle #(.TIMEOUT_ENCERRA(1'b0)) dut0 (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .nivel_in(nivel_in), .musica_in(musica_in), .fimL(fimL),
    .enderecoIgualLimite(enderecoIgualLimite),
    .botoesIgualMemoria(botoesIgualMemoria),
    .jogadafeita(jogadafeita), .timeout(timeout), .muda_nota(muda_nota),
    .zeraL(zeraL_0), .contaL(contaL_0), .zeraE(zeraE_0),
    .contaE(contaE_0), .zeraR(zeraR_0), .registraR(registraR_0),
    .zeraT(zeraT_0), .contaT(contaT_0), .zeraT2(zeraT2_0),
    .contaT2(contaT2_0), .zeraErro(zeraErro_0), .contaErro(contaErro_0),
    .zeraPontos(zeraPontos_0), .regPontos(regPontos_0),
    .mostraJ(mostraJ_0), .mostraB(mostraB_0),
    .sel_memoria_arduino(sel_memoria_arduino_0),
    .activateArduino(activateArduino_0), .nivel(nivel_0),
    .memoria(memoria_0), .fim_jogo(fim_jogo_0),
    .perdeu_timeout(perdeu_timeout_0), .db_estado(db_estado_0)
  );

  always #5 clock = ~clock;

  // datapath model: limit and address counters driven by dut strobes
  logic [4:0] m_l = 5'd0;
  logic [4:0] m_e = 5'd0;

  always @(posedge clock) begin
    if (zeraL)       m_l <= 5'd0;
    else if (contaL) m_l <= m_l + 5'd1;
    if (zeraE)       m_e <= 5'd0;
    else if (contaE) m_e <= m_e + 5'd1;
  end

  assign enderecoIgualLimite = (m_e == m_l);
  assign fimL = (m_l == (nivel ? 5'd15 : 5'd7));

  // visit counters sampled mid-cycle
  int n_fim_rod = 0, n_prox_mostra = 0, n_fim_mostra = 0;
  int n_mostra = 0, n_espera = 0, n_conta_erro = 0;
  int n_mostraj_bad = 0, n_prepara = 0;

  always @(negedge clock) begin
    if (!reset) begin
      if (db_estado == 4'hB) n_fim_rod <= n_fim_rod + 1;
      if (db_estado == 4'h4) n_prox_mostra <= n_prox_mostra + 1;
      if (db_estado == 4'h5) n_fim_mostra <= n_fim_mostra + 1;
      if (db_estado == 4'h3) n_mostra <= n_mostra + 1;
      if (db_estado == 4'h6) n_espera <= n_espera + 1;
      if (contaErro) n_conta_erro <= n_conta_erro + 1;
      if (mostraJ && db_estado != 4'h3)
        n_mostraj_bad <= n_mostraj_bad + 1;
      if (db_estado == 4'h1) n_prepara <= n_prepara + 1;
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_for(input logic [3:0] s, input int l,
                          input int e, input int budget,
                          input string nome);
    int n;
    n = 0;
    while (!(db_estado == s
             && (l < 0 || m_l == l[4:0])
             && (e < 0 || m_e == e[4:0])) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_wait: state %0d, required %0d", nome, db_estado, s);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; iniciar = 1'b1;
    nivel_in = 1'b1; musica_in = 1'b1;
    botoesIgualMemoria = 1'b1; jogadafeita = 1'b0;
    timeout = 1'b0; muda_nota = 1'b0;
    step(); step();
    checks++;
    if (db_estado !== 4'h0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", db_estado);
    end
    checks++;
    if (st !== 18'd0 || fim_jogo !== 1'b0) begin
      errors++; $display("FAIL reset_strobes: got %b expected 0", st);
    end
    checks++;
    if ({nivel, memoria, perdeu_timeout} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flops: got %b expected 000",
               {nivel, memoria, perdeu_timeout});
    end
    iniciar = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_async_reset();
    nivel_in = 1'b1; musica_in = 1'b1; muda_nota = 1'b0;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    checks++;
    if (db_estado !== 4'h1 || st !== ST_PREPARA) begin
      errors++;
      $display("FAIL prepara_decode: got %0d/%b expected 1/%b",
               db_estado, st, ST_PREPARA);
    end
    step();
    checks++;
    if (nivel !== 1'b1 || memoria !== 1'b1) begin
      errors++;
      $display("FAIL config_latch: got %b%b expected 11", nivel, memoria);
    end
    step(); step();
    checks++;
    if (db_estado !== 4'h3 || st !== ST_MOSTRA) begin
      errors++;
      $display("FAIL mostra_decode: got %0d/%b expected 3/%b",
               db_estado, st, ST_MOSTRA);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (db_estado !== 4'h0 || st !== 18'd0
        || nivel !== 1'b0 || memoria !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got %0d/%b/%b%b expected 0/0/00",
               db_estado, st, nivel, memoria);
    end
    step();
    reset = 1'b0;
  endtask

  task automatic test_full_game();
    int r0, e0, p0, s0, b0;
    nivel_in = 1'b0; musica_in = 1'b1;
    muda_nota = 1'b1; jogadafeita = 1'b1;
    botoesIgualMemoria = 1'b1; timeout = 1'b0;
    r0 = n_fim_rod; e0 = n_conta_erro; p0 = n_prox_mostra;
    s0 = n_espera; b0 = n_mostraj_bad;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    wait_for(4'hD, -1, -1, 1000, "full_game");
    checks++;
    if (n_fim_rod - r0 != 8) begin
      errors++;
      $display("FAIL rounds_8: got %0d expected 8", n_fim_rod - r0);
    end
    checks++;
    if (n_conta_erro - e0 != 0) begin
      errors++;
      $display("FAIL no_errors: got %0d expected 0", n_conta_erro - e0);
    end
    checks++;
    if (n_prox_mostra - p0 != 28 || n_espera - s0 != 36) begin
      errors++;
      $display("FAIL note_play_count: got %0d/%0d expected 28/36",
               n_prox_mostra - p0, n_espera - s0);
    end
    checks++;
    if (n_mostraj_bad != b0) begin
      errors++;
      $display("FAIL mostraJ_outside: got %0d expected 0",
               n_mostraj_bad - b0);
    end
    step();
    checks++;
    if (db_estado !== 4'hD || fim_jogo !== 1'b1 || st !== 18'd0
        || nivel !== 1'b0 || memoria !== 1'b1 || perdeu_timeout !== 1'b0) begin
      errors++;
      $display("FAIL fim_jogo_hold: got %0d/%b/%b expected 13/1/0",
               db_estado, fim_jogo, st);
    end
  endtask

  task automatic test_mostra();
    int pat[9] = '{0, 0, 1, 0, 0, 1, 0, 1, 0};
    int p0, f0, m0, b0;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    wait_for(4'h2, 2, -1, 300, "round2");
    p0 = n_prox_mostra; f0 = n_fim_mostra;
    m0 = n_mostra; b0 = n_mostraj_bad;
    for (int i = 0; i < 9; i++) begin
      muda_nota = (pat[i] != 0);
      step();
    end
    muda_nota = 1'b1;
    checks++;
    if (db_estado !== 4'h6 || st !== ST_ESPERA) begin
      errors++;
      $display("FAIL espera_decode: got %0d/%b expected 6/%b",
               db_estado, st, ST_ESPERA);
    end
    checks++;
    if (n_prox_mostra - p0 != 2 || n_fim_mostra - f0 != 1) begin
      errors++;
      $display("FAIL prox_mostra_visits: got %0d/%0d expected 2/1",
               n_prox_mostra - p0, n_fim_mostra - f0);
    end
    checks++;
    if (n_mostra - m0 != 5 || n_mostraj_bad != b0) begin
      errors++;
      $display("FAIL mostra_cycles: got %0d/%0d expected 5/0",
               n_mostra - m0, n_mostraj_bad - b0);
    end
  endtask

  task automatic test_erro();
    int e0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    wait_for(4'h6, 1, 1, 300, "round1_play2");
    e0 = n_conta_erro;
    botoesIgualMemoria = 1'b0;
    step();
    checks++;
    if (db_estado !== 4'h7 || st !== ST_REGISTRA) begin
      errors++;
      $display("FAIL registra_decode: got %0d/%b expected 7/%b",
               db_estado, st, ST_REGISTRA);
    end
    step();
    step();
    botoesIgualMemoria = 1'b1;
    checks++;
    if (db_estado !== 4'h9 || st !== ST_ERRO) begin
      errors++;
      $display("FAIL erro_decode: got %0d/%b expected 9/%b",
               db_estado, st, ST_ERRO);
    end
    step();
    checks++;
    if (db_estado !== 4'hB || st !== ST_FIM_ROD) begin
      errors++;
      $display("FAIL fim_rodada_decode: got %0d/%b expected 11/%b",
               db_estado, st, ST_FIM_ROD);
    end
    step();
    checks++;
    if (db_estado !== 4'hC || regPontos !== 1'b0
        || n_conta_erro - e0 != 1) begin
      errors++;
      $display("FAIL erro_once: got %0d/%b/%0d expected 12/0/1",
               db_estado, regPontos, n_conta_erro - e0);
    end
  endtask

  task automatic test_timeout();
    reset = 1'b1;
    step();
    reset = 1'b0;
    timeout = 1'b0; jogadafeita = 1'b0;
    muda_nota = 1'b1; botoesIgualMemoria = 1'b1;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    wait_for(4'h6, 0, 0, 100, "espera_r0");
    timeout = 1'b1; jogadafeita = 1'b1;
    step();
    timeout = 1'b0; jogadafeita = 1'b0;
    checks++;
    if (db_estado !== 4'h7 || db_estado_0 !== 4'h7) begin
      errors++;
      $display("FAIL play_over_timeout: got %0d/%0d expected 7/7",
               db_estado, db_estado_0);
    end
    wait_for(4'h6, 1, 0, 100, "espera_r1");
    step(); step();
    checks++;
    if (db_estado !== 4'h6 || db_estado_0 !== 4'h6) begin
      errors++;
      $display("FAIL espera_holds: got %0d/%0d expected 6/6",
               db_estado, db_estado_0);
    end
    timeout = 1'b1;
    step();
    timeout = 1'b0;
    checks++;
    if (db_estado !== 4'hD || perdeu_timeout !== 1'b1
        || fim_jogo !== 1'b1) begin
      errors++;
      $display("FAIL timeout_ends: got %0d/%b/%b expected 13/1/1",
               db_estado, perdeu_timeout, fim_jogo);
    end
    checks++;
    if (db_estado_0 !== 4'h9 || contaErro_0 !== 1'b1
        || perdeu_timeout_0 !== 1'b0) begin
      errors++;
      $display("FAIL timeout_as_error: got %0d/%b/%b expected 9/1/0",
               db_estado_0, contaErro_0, perdeu_timeout_0);
    end
    step();
    checks++;
    if (db_estado !== 4'hD || perdeu_timeout !== 1'b1) begin
      errors++;
      $display("FAIL perdeu_sticky: got %0d/%b expected 13/1",
               db_estado, perdeu_timeout);
    end
  endtask

  task automatic test_restart();
    int q0, r0;
    nivel_in = 1'b1; musica_in = 1'b0;
    jogadafeita = 1'b1; muda_nota = 1'b1;
    botoesIgualMemoria = 1'b1; timeout = 1'b0;
    q0 = n_prepara; r0 = n_fim_rod;
    iniciar = 1'b1;
    step();
    checks++;
    if (db_estado !== 4'h1) begin
      errors++; $display("FAIL restart: got %0d expected 1", db_estado);
    end
    step();
    checks++;
    if (perdeu_timeout !== 1'b0 || nivel !== 1'b1 || memoria !== 1'b0) begin
      errors++;
      $display("FAIL restart_flops: got %b%b%b expected 010",
               perdeu_timeout, nivel, memoria);
    end
    repeat (30) step();
    iniciar = 1'b0;
    checks++;
    if (n_prepara - q0 != 1) begin
      errors++;
      $display("FAIL held_iniciar_fim: got %0d expected 1", n_prepara - q0);
    end
    wait_for(4'hD, -1, -1, 2000, "game16");
    checks++;
    if (n_fim_rod - r0 != 16 || fim_jogo !== 1'b1) begin
      errors++;
      $display("FAIL rounds_16: got %0d expected 16", n_fim_rod - r0);
    end
  endtask

  task automatic test_held_iniciar_inicial();
    int q0;
    reset = 1'b1; iniciar = 1'b1;
    step();
    q0 = n_prepara;
    reset = 1'b0;
    repeat (30) step();
    iniciar = 1'b0;
    checks++;
    if (n_prepara - q0 != 1) begin
      errors++;
      $display("FAIL held_iniciar_inicial: got %0d expected 1",
               n_prepara - q0);
    end
  endtask

  task automatic test_illegal();
    force dut.estado = s1_pkg::estado_t'(4'hE);
    #1;
    checks++;
    if (db_estado !== 4'hE || st !== 18'd0 || fim_jogo !== 1'b0) begin
      errors++;
      $display("FAIL illegal_decode: got %0d/%b expected 14/0",
               db_estado, st);
    end
    checks++;
    if (dut.estado_prox !== 4'h0) begin
      errors++;
      $display("FAIL illegal_next: got %0d expected 0", dut.estado_prox);
    end
    release dut.estado;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    checks++;
    if (db_estado !== 4'h0) begin
      errors++;
      $display("FAIL after_illegal: got %0d expected 0", db_estado);
    end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_full_game();
    test_mostra();
    test_erro();
    test_timeout();
    test_restart();
    test_held_iniciar_inicial();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
